// File: rtl/pdm_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module      : pdm_cic_decimator
// Description : Third-order CIC decimator. It converts a 1-bit PDM stream
//               into unsigned PCM samples, producing one sample for every
//               R = 2**LOG2_DECIM accepted PDM bits.
//
// Ports       : clk        in   1       clock, all state changes on rising edge
//               rst        in   1       synchronous reset, active-high
//               en         in   1       PDM sample strobe (pdm_in accepted when 1)
//               pdm_in     in   1       PDM bit, 1 -> +1, 0 -> 0
//               pcm_out    out  ACC_W   unsigned PCM sample, 0..R**3
//               pcm_valid  out  1       one-clk pulse: pcm_out updated
//
// Parameters  : LOG2_DECIM  decimation exponent, legal range 2..6
//               ACC_W       3*LOG2_DECIM+1 (derived, not overridable)
//
// Revision    : 1.0  initial release
// ============================================================================
module pdm_cic_decimator #(
    parameter int LOG2_DECIM = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    pdm_in,
    output logic [3*LOG2_DECIM:0]   pcm_out,
    output logic                    pcm_valid
);

    localparam int ACC_W = 3 * LOG2_DECIM + 1;
    // Last count value of a frame (R-1); the counter wraps naturally after it.
    localparam logic [LOG2_DECIM-1:0] CNT_LAST = '1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [ACC_W-1:0]      i1_q, i2_q, i3_q;
    logic [ACC_W-1:0]      i1_d, i2_d, i3_d;
    logic [ACC_W-1:0]      d1_q, d2_q, d3_q;
    logic [ACC_W-1:0]      d1_d, d2_d, d3_d;
    logic [LOG2_DECIM-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]      pcm_q, pcm_d;
    logic                  valid_q, valid_d;

    logic                  tick;
    logic [ACC_W-1:0]      pdm_ext;
    logic [ACC_W-1:0]      c1, c2, c3;

    assign tick    = en & (cnt_q == CNT_LAST);
    assign pdm_ext = {{(ACC_W-1){1'b0}}, pdm_in};

    // Comb section works on the pre-edge integrator output. All arithmetic is
    // modulo 2**ACC_W; the final difference is exact because the true result
    // never exceeds R**3 < 2**ACC_W.
    assign c1 = i3_q - d1_q;
    assign c2 = c1 - d2_q;
    assign c3 = c2 - d3_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        i1_d    = i1_q;
        i2_d    = i2_q;
        i3_d    = i3_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        cnt_d   = cnt_q;
        pcm_d   = pcm_q;
        valid_d = 1'b0;

        if (en) begin
            // Each stage accumulates the previous stage's pre-edge value, so
            // the cascade carries one register of delay per stage.
            i1_d  = i1_q + pdm_ext;
            i2_d  = i2_q + i1_q;
            i3_d  = i3_q + i2_q;
            cnt_d = cnt_q + 1'b1;
        end

        if (tick) begin
            d1_d    = i3_q;
            d2_d    = c1;
            d3_d    = c2;
            pcm_d   = c3;
            valid_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            i1_q    <= '0;
            i2_q    <= '0;
            i3_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            cnt_q   <= '0;
            pcm_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            i1_q    <= i1_d;
            i2_q    <= i2_d;
            i3_q    <= i3_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            cnt_q   <= cnt_d;
            pcm_q   <= pcm_d;
            valid_q <= valid_d;
        end
    end

    assign pcm_out   = pcm_q;
    assign pcm_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pdm_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdm_cic_decimator
// Description : Testbench for pdm_cic_decimator. Drives an R=16 and an R=4
//               instance with identical stimulus and compares both against a
//               closed-form CIC model built from the history of accepted bits.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pdm_cic_decimator;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        pdm_in;
    logic [12:0] pcm16;
    logic        v16;
    logic [6:0]  pcm4;
    logic        v4;

    always #5 clk = ~clk;

    pdm_cic_decimator #(.LOG2_DECIM(4)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pdm_in    (pdm_in),
        .pcm_out   (pcm16),
        .pcm_valid (v16)
    );

    pdm_cic_decimator #(.LOG2_DECIM(2)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pdm_in    (pdm_in),
        .pcm_out   (pcm4),
        .pcm_valid (v4)
    );

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    bit          hist[$];       // accepted PDM bits since the last reset
    int          checks = 0;
    int          passes = 0;
    logic [12:0] e16;
    logic [6:0]  e4;
    logic        ev16, ev4;
    int          nv16, nv4;
    int          steady16, steady4;   // -1 disables the steady-value check

    // Integrator-cascade output after m accepted bits. Three one-register
    // stages give i3[m] = sum_n x[n] * C(m-1-n, 2).
    function automatic longint s_val(int k, int r);
        longint acc;
        int     m;
        int     a;
        acc = 0;
        if (k <= 0) return 0;
        m = k * r - 1;          // pre-edge state at the k-th tick
        for (int n = 0; n <= m - 3; n++) begin
            a = m - 1 - n;
            if (hist[n]) acc += longint'(a) * longint'(a - 1) / 2;
        end
        return acc;
    endfunction

    // Third difference of the decimated integrator output, reduced to width.
    function automatic longint cic_y(int k, int r, int accw);
        longint d;
        d = s_val(k, r) - 3 * s_val(k - 1, r) + 3 * s_val(k - 2, r) - s_val(k - 3, r);
        return d & ((64'sd1 <<< accw) - 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock with the given inputs; model update and checks after the edge.
    task automatic cycle(input bit r, input bit e, input bit d);
        rst    = r;
        en     = e;
        pdm_in = d;
        @(posedge clk);
        #1;
        ev16 = 1'b0;
        ev4  = 1'b0;
        if (r) begin
            hist.delete();
            e16  = '0;
            e4   = '0;
            nv16 = 0;
            nv4  = 0;
        end else if (e) begin
            hist.push_back(d);
            if (hist.size() % 16 == 0) begin
                ev16 = 1'b1;
                nv16++;
                e16  = 13'(cic_y(hist.size() / 16, 16, 13));
            end
            if (hist.size() % 4 == 0) begin
                ev4 = 1'b1;
                nv4++;
                e4  = 7'(cic_y(hist.size() / 4, 4, 7));
            end
        end
        chk("valid16", {63'd0, v16}, {63'd0, ev16});
        chk("pcm16",   {51'd0, pcm16}, {51'd0, e16});
        chk("valid4",  {63'd0, v4}, {63'd0, ev4});
        chk("pcm4",    {57'd0, pcm4}, {57'd0, e4});
        if (ev16 && steady16 >= 0 && nv16 >= 4)
            chk("steady16", {51'd0, pcm16}, 64'(steady16));
        if (ev4 && steady4 >= 0 && nv4 >= 4)
            chk("steady4", {57'd0, pcm4}, 64'(steady4));
    endtask

    // ------------------------------------------------------------------------
    // Directed and randomized sequence
    // ------------------------------------------------------------------------
    initial begin
        int gap;
        rst      = 1'b1;
        en       = 1'b0;
        pdm_in   = 1'b0;
        steady16 = -1;
        steady4  = -1;
        e16      = '0;
        e4       = '0;

        // 1: reset, then all-zero stream
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        chk("rst_pcm16",   {51'd0, pcm16}, 64'd0);
        chk("rst_valid16", {63'd0, v16},   64'd0);
        steady16 = 0;
        steady4  = 0;
        for (int i = 0; i < 128; i++) cycle(0, 1, 0);
        chk("zero_valid_count", 64'(nv16), 64'd8);

        // 2: constant ones at full rate (R=16 -> 4096, R=4 -> 64)
        cycle(1, 0, 0);
        steady16 = 4096;
        steady4  = 64;
        for (int i = 0; i < 160; i++) cycle(0, 1, 1);
        chk("ones_valid_count", 64'(nv16), 64'd10);

        // 3: alternating 1,0 at full rate -> half scale
        cycle(1, 0, 0);
        steady16 = 2048;
        steady4  = 32;
        for (int i = 0; i < 160; i++) cycle(0, 1, (i % 2) == 0);

        // 4: en every third clock, ones; output holds while en is low
        cycle(1, 0, 0);
        steady16 = 4096;
        steady4  = 64;
        for (int i = 0; i < 48 * 6; i++) cycle(0, (i % 3) == 0, 1);
        chk("strobe_valid_count", 64'(nv16), 64'd6);

        // 5: reset mid-frame (after 7 accepted bits) with ones streaming
        cycle(1, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 1, 1);
        cycle(1, 1, 1);
        gap = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 1, 1);
            gap++;
            if (v16) break;
        end
        chk("rst_gap16", 64'(gap), 64'd16);
        for (int i = 0; i < 80; i++) cycle(0, 1, 1);

        // 6: short-frame instance, constant ones, valid every 4 en
        cycle(1, 0, 0);
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 1);
            gap++;
            if (v4) break;
        end
        chk("first_gap4", 64'(gap), 64'd4);
        for (int i = 0; i < 40; i++) cycle(0, 1, 1);
        chk("steady_pcm4", {57'd0, pcm4}, 64'd64);

        // Randomized: sparse en, random bits, occasional reset
        steady16 = -1;
        steady4  = -1;
        cycle(1, 0, 0);
        for (int i = 0; i < 1200; i++)
            cycle(($urandom % 300) == 0, ($urandom % 4) != 0, $urandom % 2);
        // Dense, biased-density stream
        for (int i = 0; i < 400; i++)
            cycle(0, 1, ($urandom % 8) < 6);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
